parity_frame_rx: RTL and testbench
==================================

# parity_frame_rx

Serial frame receiver that sits directly upstream of the team's 9-bit even-parity logic on the receive path. It recovers a start / 9 data / even-parity / stop frame from an idle-high serial line using an oversampling tick. It checks even parity over data plus parity bit and presents the word, with error flags, on a valid/ready output register.

## Interface
- `DATA_W`, 9: data bits per frame, sent LSB first.
- `OVS`, 16: ticks per bit period; even, ≥4.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `tick`  in  1  single-cycle oversample strobe, OVS per bit time.
- `rxd`  in  1  serial line, idle high (already synchronised to `clk`).
- `data`  out  DATA_W  received word.
- `valid`  out  1  output register holds an unconsumed frame.
- `ready`  in  1  consumer accepts the frame when `valid && ready`.
- `parity_err`  out  1  XOR of data bits and parity bit is 1; qualified by `valid`.
- `frame_err`  out  1  stop bit sampled 0; qualified by `valid`.
- `overrun`  out  1  sticky; a completed frame was dropped because the output register was full.

## Operation
- Reset: FSM=IDLE, armed=0, tick counter=0, shift register=0. Outputs: `data`=0, `valid`=0, `parity_err`=0, `frame_err`=0, `overrun`=0. Reset asserted mid-frame aborts the frame.
- Arming: IDLE accepts a start only when armed=1. armed is set on any tick with `rxd`=1 and cleared on leaving IDLE. This means a stuck-low line after reset or a break never creates frames.
- FSM states: IDLE → START → DATA → PARITY → STOP → IDLE.
- IDLE: on a tick with `rxd`=0 and armed=1, go to START with cnt=0.
- START: on a tick with cnt==OVS/2−1, sample `rxd`.
  - If 0, go to DATA with cnt=0 and bit index=0.
  - If 1 (glitch), go to IDLE.
  - Otherwise the tick does cnt++.
- DATA, PARITY, STOP sample `rxd` on a tick with cnt==OVS−1, then set cnt=0. Otherwise the tick does cnt++.
- DATA: the sampled bit shifts into position [bit index], LSB first. After DATA_W samples, go to PARITY.
- PARITY: store the parity bit. `parity_err` = ^{shift, parity bit}.
- STOP: `frame_err` = !rxd. The frame completes and the FSM goes to IDLE (armed=0).
- Completion with output register empty, or with `valid && ready` in the same cycle: load `data`, `parity_err` and `frame_err`, and hold `valid`=1.
- Completion with `valid && !ready`: drop the new frame, keep the old contents, set `overrun`=1.
- Handshake:
  - `data` and the flags stay stable while `valid && !ready`.
  - On `valid && ready` with no completion in that cycle, `valid`=0 next cycle.
  - `overrun` clears on the cycle following a `valid && ready` transfer.
- `tick` with the FSM in IDLE and `rxd`=1 only sets armed. Cycles without `tick` change nothing except the handshake.

## Timing
- Samples land at mid-bit: first data sample at OVS/2 + OVS ticks after start detection.
- Latency: `valid` rises one `clk` after the tick that samples the stop bit. From the detecting tick, that tick is the (OVS/2 + OVS·(DATA_W+2))-th tick.
- Throughput: one frame per DATA_W+3 bit times. Back-to-back frames are supported because STOP returns to IDLE at the stop-bit midpoint, and the line is high for the rest of the stop bit, which re-arms.
- All outputs are registered; no combinational path from `rxd` or `ready` to any output.

## Structure
- Shared package `parity_rx_pkg`:
  - state encoding localparams (IDLE, START, DATA, PARITY, STOP; 3 bits);
  - default DATA_W=9 and OVS=16.
- One sub-module, `rx_parity_chk`: combinational XOR reduction over DATA_W+1 bits producing `parity_err`. Reusable by the transmit side.
- Top holds FSM, tick counter (clog2(OVS) bits), bit index (clog2(DATA_W+1) bits), shift register and output register.

## Test plan
- OVS=16. Send 9'b000011000, parity 0, stop 1, `ready`=1 → one-cycle `valid`, `data`=9'h018, `parity_err`=0, `frame_err`=0.
- Send 9'b000111011 with parity bit 0 → `valid`, `data`=9'h03B, `parity_err`=1.
- Send 9'b011011000, parity 0, stop bit 0 → `frame_err`=1. Hold `rxd`=0 for 40 bit times → no further `valid`. Release high, send 9'b011111011 with parity 1 → `data`=9'h0FB, no errors.
- `rxd` low for 4 ticks then high → no `valid`, FSM back in IDLE; following good frame received correctly.
- `ready`=0, send two good frames → first held unchanged and `overrun`=1 after the second. Then `ready`=1 for one cycle → first frame transferred, `valid`=0 and `overrun`=0 next cycle.
- Assert `rst_n`=0 during data bit 4 → all outputs 0 immediately. After release, `rxd` high, then a good frame → correct `data`, no errors.

Source files
------------

// File: rtl/parity_frame_rx_pkg.sv
// rtl/parity_frame_rx_pkg.sv - shared state encoding and default parameters for the parity frame receiver
// Contents: receiver FSM state type, default data width and oversampling ratio.
package parity_rx_pkg;

  localparam int DEF_DATA_W = 9;
  localparam int DEF_OVS    = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

endpackage

// File: rtl/parity_frame_rx_if.sv
// rtl/parity_frame_rx_if.sv - valid/ready output bus of the parity frame receiver
// Signals: data, valid, parity_err, frame_err, overrun (receiver to consumer), ready (consumer to receiver).
// master: receiver side; slave: consumer side.
interface parity_frame_rx_if
  import parity_rx_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;
  logic              parity_err;
  logic              frame_err;
  logic              overrun;

  modport master (
    output data, valid, parity_err, frame_err, overrun,
    input  ready
  );

  modport slave (
    input  data, valid, parity_err, frame_err, overrun,
    output ready
  );

endinterface

// File: rtl/parity_frame_rx_chk.sv
// rtl/parity_frame_rx_chk.sv - even-parity checker, XOR reduction over data plus parity bit
// Ports: i_bits (W) data and parity bit together; o_err is 1 when the count of ones is odd.
module rx_parity_chk #(
  parameter int W = 10
) (
  input  logic [W-1:0] i_bits,
  output logic         o_err
);

  assign o_err = ^i_bits;

endmodule

// File: rtl/parity_frame_rx.sv
// rtl/parity_frame_rx.sv - oversampled start/data/parity/stop frame receiver with valid/ready output register
// Ports: clk, rst_n (async active-low), tick (oversample strobe, OVS per bit), rxd (synchronised
// serial line, idle high), bus (master modport: data, valid, parity_err, frame_err, overrun out; ready in).
module parity_frame_rx
  import parity_rx_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OVS    = DEF_OVS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 rxd,
  parity_frame_rx_if.master    bus
);

  localparam int CNT_W = $clog2(OVS);
  localparam int IDX_W = $clog2(DATA_W + 1);

  // START samples at half a bit so every later sample lands mid-bit.
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVS / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OVS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  rx_state_t         r_state;
  logic              r_armed;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_shift;
  logic              r_par;

  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_perr;
  logic              r_ferr;
  logic              r_overrun;

  logic              w_perr;
  logic              w_take;

  rx_parity_chk #(
    .W (DATA_W + 1)
  ) u_chk (
    .i_bits ({r_par, r_shift}),
    .o_err  (w_perr)
  );

  // Output register can accept a new frame when empty or being drained this cycle.
  assign w_take = !r_valid || bus.ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_armed   <= 1'b0;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (r_valid && bus.ready) begin
        r_valid   <= 1'b0;
        r_overrun <= 1'b0;
      end

      if (tick) begin
        case (r_state)
          ST_IDLE: begin
            // Arming requires a high line first, so a stuck-low line never frames.
            if (rxd) begin
              r_armed <= 1'b1;
            end else if (r_armed) begin
              r_state <= ST_START;
              r_cnt   <= '0;
              r_armed <= 1'b0;
            end
          end

          ST_START: begin
            if (r_cnt == CNT_HALF) begin
              r_cnt <= '0;
              if (!rxd) begin
                r_state <= ST_DATA;
                r_idx   <= '0;
              end else begin
                // Start glitch: line is already high again, so it counts as arming.
                r_state <= ST_IDLE;
                r_armed <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end

          ST_DATA: begin
            if (r_cnt == CNT_FULL) begin
              r_cnt          <= '0;
              r_shift[r_idx] <= rxd;
              if (r_idx == IDX_LAST) begin
                r_state <= ST_PARITY;
              end else begin
                r_idx <= r_idx + IDX_W'(1);
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end

          ST_PARITY: begin
            if (r_cnt == CNT_FULL) begin
              r_cnt   <= '0;
              r_par   <= rxd;
              r_state <= ST_STOP;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end

          ST_STOP: begin
            if (r_cnt == CNT_FULL) begin
              r_cnt   <= '0;
              r_state <= ST_IDLE;
              r_armed <= 1'b0;
              if (w_take) begin
                r_data  <= r_shift;
                r_perr  <= w_perr;
                r_ferr  <= !rxd;
                r_valid <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end

          default: begin
            r_state <= ST_IDLE;
            r_armed <= 1'b0;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.data       = r_data;
  assign bus.valid      = r_valid;
  assign bus.parity_err = r_perr;
  assign bus.frame_err  = r_ferr;
  assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_parity_frame_rx.sv
// tb/tb_parity_frame_rx.sv - scoreboard testbench for parity_frame_rx
module tb_parity_frame_rx;
  import parity_rx_pkg::*;

  localparam int DW  = 9;
  localparam int OVS = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic tick  = 1'b0;
  logic rxd   = 1'b1;

  int n_cmp   = 0;
  int n_bad   = 0;
  int div     = 0;
  int rdy_mode = 1;  // 0: hold low, 1: hold high, 2: random

  // {frame_err, parity_err, data}
  logic [DW+1:0] exp_q[$];

  parity_frame_rx_if #(.DATA_W(DW)) bus ();

  parity_frame_rx #(
    .DATA_W (DW),
    .OVS    (OVS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick),
    .rxd   (rxd),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      tick = (div == 0);
      div  = (div + 1) % 3;
    end
  end

  initial begin
    bus.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 2) bus.ready = ($urandom_range(0, 3) != 0);
      else               bus.ready = (rdy_mode == 1);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic model_perr(input logic [DW-1:0] d, input logic p);
    return (($countones(d) + int'(p)) % 2) == 1;
  endfunction

  initial begin
    logic [DW+1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.valid && bus.ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_valid: got data %0h expected no frame", bus.data);
        end else begin
          e = exp_q.pop_front();
          check("rx_data", 32'(bus.data), 32'(e[DW-1:0]));
          check("rx_parity_err", 32'(bus.parity_err), 32'(e[DW]));
          check("rx_frame_err", 32'(bus.frame_err), 32'(e[DW+1]));
        end
      end
    end
  end

  task automatic wait_tick();
    @(posedge clk);
    while (!tick) @(posedge clk);
  endtask

  task automatic hold_line(input logic v, input int n);
    #1 rxd = v;
    repeat (n) wait_tick();
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic par, input logic stop,
                            input int idle_bits, input bit push, input bit chk_lat);
    hold_line(1'b0, OVS);
    for (int i = 0; i < DW; i++) hold_line(d[i], OVS);
    hold_line(par, OVS);
    if (push) exp_q.push_back({~stop, model_perr(d, par), d});
    hold_line(stop, OVS / 2);
    if (chk_lat) begin
      #1;
      check("valid_before_stop_sample", 32'(bus.valid), 32'd0);
    end
    wait_tick();
    if (chk_lat) begin
      #1;
      check("valid_latency", 32'(bus.valid), 32'd1);
    end
    repeat (OVS - OVS / 2 - 1) wait_tick();
    if (idle_bits > 0) hold_line(1'b1, idle_bits * OVS);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"},       32'(bus.data),       32'd0);
    check({tag, "_valid"},      32'(bus.valid),      32'd0);
    check({tag, "_parity_err"}, 32'(bus.parity_err), 32'd0);
    check({tag, "_frame_err"},  32'(bus.frame_err),  32'd0);
    check({tag, "_overrun"},    32'(bus.overrun),    32'd0);
  endtask

  initial begin
    logic [DW-1:0] d;
    logic          p;
    logic          s;
    int            idle;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    hold_line(1'b1, 2 * OVS);

    send_frame(9'h018, 1'b0, 1'b1, 2, 1'b1, 1'b1);
    send_frame(9'h03B, 1'b0, 1'b1, 2, 1'b1, 1'b1);
    send_frame(9'h0D8, 1'b0, 1'b0, 0, 1'b1, 1'b1);
    hold_line(1'b0, 40 * OVS);
    hold_line(1'b1, 2 * OVS);
    send_frame(9'h0FB, 1'b1, 1'b1, 2, 1'b1, 1'b1);

    hold_line(1'b0, 4);
    hold_line(1'b1, 2 * OVS);
    send_frame(9'h155, 1'b0, 1'b1, 2, 1'b1, 1'b1);
    wait_drain();

    // Overrun: hold ready low, second frame must be dropped.
    rdy_mode = 0;
    @(posedge clk);
    send_frame(9'h0A5, 1'b1, 1'b1, 1, 1'b1, 1'b0);
    check("overrun_after_first", 32'(bus.overrun), 32'd0);
    send_frame(9'h05A, 1'b0, 1'b1, 1, 1'b0, 1'b0);
    check("hold_valid", 32'(bus.valid), 32'd1);
    check("hold_data", 32'(bus.data), 32'h0A5);
    check("hold_parity_err", 32'(bus.parity_err), 32'(model_perr(9'h0A5, 1'b1)));
    check("overrun_set", 32'(bus.overrun), 32'd1);
    @(posedge clk);
    #2 rdy_mode = 1;
    @(posedge clk);
    #2 rdy_mode = 0;
    @(posedge clk);
    #2;
    check("valid_after_transfer", 32'(bus.valid), 32'd0);
    check("overrun_after_transfer", 32'(bus.overrun), 32'd0);
    check("queue_after_transfer", 32'(exp_q.size()), 32'd0);

    // Reset mid-frame with a held frame in the output register.
    send_frame(9'h1C3, 1'b1, 1'b1, 1, 1'b0, 1'b0);
    check("held_before_reset_valid", 32'(bus.valid), 32'd1);
    check("held_before_reset_data", 32'(bus.data), 32'h1C3);
    d = 9'h0B6;
    hold_line(1'b0, OVS);
    for (int i = 0; i < 4; i++) hold_line(d[i], OVS);
    hold_line(d[4], OVS / 2);
    #1 rst_n = 1'b0;
    #1;
    check_all_zero("midframe_reset");
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 2;
    hold_line(1'b1, 2 * OVS);
    send_frame(9'h09C, 1'b1, 1'b1, 2, 1'b1, 1'b1);

    // Randomised frames, including back-to-back and bad parity/stop.
    for (int k = 0; k < 14; k++) begin
      d    = DW'($urandom_range(0, (1 << DW) - 1));
      p    = 1'($urandom_range(0, 1));
      s    = ($urandom_range(0, 5) != 0);
      idle = $urandom_range(0, 2);
      if (!s && idle == 0) idle = 1;
      send_frame(d, p, s, idle, 1'b1, 1'b1);
    end

    hold_line(1'b1, OVS);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
